// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: sender state encoding and default depth.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

    localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte buffer with registered occupancy; full/empty derive from the count register only.
// The occupancy output exists only when UART_TX_FIFO_LEVEL_EN is defined.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  head_data,
    output logic        full,
    output logic        empty
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [AW:0] count
`endif
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

`ifdef UART_TX_FIFO_LEVEL_EN
    assign count = count_q;
`endif

    // A push against a full buffer is rejected even if a pop happens in the same cycle.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART serializer: one tx_de pulse per byte, next byte only after tx_done.
// Define UART_TX_FIFO_LEVEL_EN to expose the occupancy count on port level.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        tx_de,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [AW:0] level
`endif
);

    tx_state_e  state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       overflow_q, overflow_d;
    logic [7:0] head_data;
    logic       pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .count     (level)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // tx_done only matters in WAIT; the head byte is latched as we leave IDLE.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d   = SEND;
                    tx_data_d = head_data;
                end
            end
            SEND:    state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | (wr_en & full);
    end

    always_comb begin
        tx_de    = (state_q == SEND);
        pop      = (state_q == SEND);
        busy     = (state_q != IDLE);
        tx_data  = tx_data_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a DEPTH=16 instance for data flow and a DEPTH=4 instance for overflow.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       resp_done;
    logic       stray_done;
    logic       tx_done;
    logic       full, empty, overflow, tx_de, busy;
    logic [7:0] tx_data;

    logic       d4_wr_en;
    logic [7:0] d4_wr_data;
    logic       d4_tx_done;
    logic       d4_full, d4_empty, d4_overflow, d4_tx_de, d4_busy;
    logic [7:0] d4_tx_data;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
    logic [2:0] d4_level;
`endif

    assign tx_done = resp_done | stray_done;

    uart_tx_fifo #(.DEPTH(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .tx_de    (tx_de),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    uart_tx_fifo #(.DEPTH(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (d4_wr_en),
        .wr_data  (d4_wr_data),
        .full     (d4_full),
        .empty    (d4_empty),
        .overflow (d4_overflow),
        .tx_de    (d4_tx_de),
        .tx_data  (d4_tx_data),
        .tx_done  (d4_tx_done),
        .busy     (d4_busy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level    (d4_level)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         de_cnt = 0;
    int         d4_de_cnt = 0;
    int         last_de_cyc = 0;
    int         last_done_cyc = 0;
    bit         b2b_pend = 1'b0;
    logic [7:0] last_sent = 8'h00;
    logic [7:0] q[$];
    logic [7:0] q4[$];
    int         frame_len = 20;
    bit         d4_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serializer stand-ins: answer each tx_de with a tx_done pulse a fixed number of cycles later.
    initial begin
        int cnt;
        cnt = 0;
        resp_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            if (rst || !busy) begin
                cnt = 0;
            end else if (tx_de) begin
                cnt = frame_len;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) resp_done = 1'b1;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        d4_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            d4_tx_done = 1'b0;
            if (rst || !d4_busy) begin
                cnt = 0;
            end else if (d4_tx_de) begin
                cnt = 3;
            end else if (d4_en && cnt > 0) begin
                cnt--;
                if (cnt == 0) d4_tx_done = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            b2b_pend = 1'b0;
        end else if (tx_de) begin
            de_cnt++;
            last_de_cyc = cyc;
            last_sent = tx_data;
            chk("busy_at_de", busy, 1);
            if (q.size() == 0) chk("unexpected_tx_de", 1, 0);
            else chk("tx_data", tx_data, q.pop_front());
            if (b2b_pend) chk("b2b_gap", cyc - last_done_cyc, 2);
            b2b_pend = 1'b0;
        end else if (busy && tx_done) begin
            chk("tx_data_hold", tx_data, last_sent);
            last_done_cyc = cyc;
            b2b_pend = !empty;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && d4_tx_de) begin
            d4_de_cnt++;
            if (q4.size() == 0) chk("d4_unexpected_tx_de", 1, 0);
            else chk("d4_tx_data", d4_tx_data, q4.pop_front());
        end
    end

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        q.push_back(b);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_de(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (de_cnt >= target) break;
            @(posedge clk);
            #1;
        end
        if (i == budget) chk("de_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy && empty && q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (i == budget) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int w;
        int c0;
        logic [2:0] exp_lvl [6];
        exp_lvl = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};

        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        stray_done = 1'b0;
        d4_wr_en = 1'b0;
        d4_wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_de", tx_de, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rst_level", level, 0);
`endif
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Single byte latency and hold
        c0 = de_cnt;
        w = cyc;
        write_byte(8'hA5);
        wait_de(c0 + 1, 20);
        chk("latency", last_de_cyc - w, 2);
        chk("busy_after_de", busy, 1);
        wait_idle(200);
        chk("single_cnt", de_cnt - c0, 1);

        // Burst of four
        c0 = de_cnt;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            q.push_back(8'(i));
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_idle(500);
        chk("burst_cnt", de_cnt - c0, 4);
        chk("burst_empty", empty, 1);

        // Three full-depth rounds across the pointer wrap
        c0 = de_cnt;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                wr_en = 1'b1;
                wr_data = 8'(8'h40 + r * 16 + i);
                q.push_back(8'(8'h40 + r * 16 + i));
                @(posedge clk);
                #1;
            end
            wr_en = 1'b0;
            wait_idle(2000);
        end
        chk("wrap_cnt", de_cnt - c0, 48);
        chk("wrap_overflow", overflow, 0);

        // Stray tx_done while idle
        c0 = de_cnt;
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_busy", busy, 0);
        chk("stray_no_de", de_cnt, c0);
        chk("stray_empty", empty, 1);

        // Reset while a frame is outstanding with bytes queued
        frame_len = 200;
        c0 = de_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h60 + i);
            q.push_back(8'(8'h60 + i));
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_de(c0 + 1, 20);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_empty", empty, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        chk("mrst_tx_de", tx_de, 0);
        chk("mrst_tx_data", tx_data, 8'h00);
        chk("mrst_busy", busy, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_full", full, 0);
        chk("mrst_overflow", overflow, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("mrst_level", level, 0);
`endif
        c0 = de_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_no_de", de_cnt, c0);
        frame_len = 20;
        write_byte(8'h77);
        wait_idle(200);
        chk("post_rst_cnt", de_cnt - c0, 1);

        // Overflow on the four-entry instance, serializer held off
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("d4_level_start", d4_level, 0);
`endif
        for (int i = 0; i < 6; i++) begin
            d4_wr_en = 1'b1;
            d4_wr_data = 8'(8'h10 + i);
            if (i < 5) q4.push_back(8'(8'h10 + i));
            @(posedge clk);
            #1;
            chk("d4_full", d4_full, (i >= 4) ? 1 : 0);
            chk("d4_overflow_step", d4_overflow, (i == 5) ? 1 : 0);
`ifdef UART_TX_FIFO_LEVEL_EN
            chk("d4_level", d4_level, exp_lvl[i]);
`endif
        end
        d4_wr_en = 1'b0;
        d4_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!d4_busy && d4_empty && q4.size() == 0) break;
            @(posedge clk);
            #1;
            if (i == 199) chk("d4_idle_timeout", 0, 1);
        end
        chk("d4_sent", d4_de_cnt, 5);
        chk("d4_empty_end", d4_empty, 1);
        chk("d4_overflow_sticky", d4_overflow, 1);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("d4_level_end", d4_level, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
